cnn_frame_controller: RTL and testbench

CNN_FRAME_CONTROLLER -- requirements
Module: cnn_frame_controller

---
 rtl/cnn_frame_controller.sv | 138 +++++++++++++
 tb/tb_cnn_frame_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_frame_controller.sv
// Frame sequencer for a streaming CNN core: feeds one frame of pixels, drains the
// pipeline, buffers each result in a one-deep output register and reports progress.
module cnn_frame_controller #(
  parameter int CHANNELS_IN  = 3,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 32,
  parameter int OUT_PIXELS   = 128,
  parameter int FLUSH_LIMIT  = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [8*CHANNELS_IN-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     cnn_clk_en,
  output logic [8*CHANNELS_IN-1:0] cnn_input_data,
  input  logic [79:0]              cnn_output_data,
  input  logic                     cnn_valid,
  output logic [79:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     timeout,
  output logic [15:0]              in_count,
  output logic [15:0]              out_count
);

  localparam int IN_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int FW        = (FLUSH_LIMIT > 1) ? $clog2(FLUSH_LIMIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

  state_e          state_q, state_d;
  logic [15:0]     in_count_q, in_count_d;
  logic [15:0]     out_count_q, out_count_d;
  logic [79:0]     out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            timeout_q, timeout_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;

  logic stall, accept, capture, start_acc, in_last, out_last, flush_expired;

  // A pending result blocks the core so a new capture can never overwrite it.
  assign stall         = out_valid_q & ~out_ready;
  assign accept        = cnn_clk_en & (state_q == LOAD);
  assign capture       = cnn_clk_en & cnn_valid;
  assign start_acc     = (state_q == IDLE) & start;
  assign in_last       = accept  & (({16'd0, in_count_q}  + 32'd1) == 32'(IN_PIXELS));
  assign out_last      = capture & (({16'd0, out_count_q} + 32'd1) == 32'(OUT_PIXELS));
  assign flush_expired = (state_q == FLUSH) & (flush_cnt_q == FW'(FLUSH_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD: begin
        if (out_last)     state_d = DONE;
        else if (in_last) state_d = FLUSH;
      end
      FLUSH:   if (out_last || flush_expired) state_d = DONE;
      DONE:    if (!out_valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE);
    in_ready       = (state_q == LOAD) & ~stall;
    cnn_clk_en     = ~stall & (((state_q == LOAD) & in_valid) | (state_q == FLUSH));
    cnn_input_data = (state_q == LOAD) ? in_data : '0;
    frame_done     = (state_q == DONE) & ~out_valid_q;
  end

  always_comb begin
    in_count_d  = in_count_q;
    out_count_d = out_count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    timeout_d   = timeout_q;
    flush_cnt_d = (state_q == FLUSH) ? flush_cnt_q + 1'b1 : '0;

    if (start_acc) begin
      in_count_d  = '0;
      out_count_d = '0;
      timeout_d   = 1'b0;
    end else begin
      if (accept && in_count_q != 16'hFFFF)
        in_count_d = in_count_q + 16'd1;
      if (capture && out_count_q != 16'hFFFF)
        out_count_d = out_count_q + 16'd1;
      // Timeout only when the final result did not arrive on the same cycle.
      if (flush_expired && !out_last)
        timeout_d = 1'b1;
    end

    if (capture) begin
      out_data_d  = cnn_output_data;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_count_q  <= '0;
      out_count_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign timeout   = timeout_q;
  assign in_count  = in_count_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_cnn_frame_controller.sv
// Directed-plus-random bench for cnn_frame_controller with a small stub CNN that
// emits its two results on its 5th and 10th enabled cycles of each frame.
module tb_cnn_frame_controller;

  localparam int CH   = 3;
  localparam int DW   = 8 * CH;
  localparam int NPIX = 8;
  localparam int OUTP = 2;
  localparam int FL   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          cnn_clk_en;
  logic [DW-1:0] cnn_input_data;
  logic [79:0]   cnn_output_data;
  logic          cnn_valid;
  logic [79:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy, frame_done, timeout;
  logic [15:0]   in_count, out_count;

  cnn_frame_controller #(
    .CHANNELS_IN(CH), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2),
    .OUT_PIXELS(OUTP), .FLUSH_LIMIT(FL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cnn_clk_en(cnn_clk_en), .cnn_input_data(cnn_input_data),
    .cnn_output_data(cnn_output_data), .cnn_valid(cnn_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done), .timeout(timeout),
    .in_count(in_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Stub CNN: counts its enabled cycles in the frame; valid after the 4th and 9th.
  int          k;
  logic        stub_en = 1'b1;
  logic [63:0] tag = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               k <= 0;
    else if (start && !busy)  k <= 0;
    else if (cnn_clk_en)      k <= k + 1;
  end

  assign cnn_valid       = stub_en && (k == 4 || k == 9);
  assign cnn_output_data = {tag, k[15:0]};

  int            n_cmp = 0;
  int            n_err = 0;
  int            acc = 0;
  int            fd_total = 0;
  int            en_total = 0;
  logic [DW-1:0] fed_q[$];
  logic [79:0]   got_q[$];

  task automatic check(input string name, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, return just after the next rising edge.
  task automatic sample();
    @(negedge clk);
    if (busy) check("in_count_track", 80'(in_count), 80'(acc));
    if (out_valid && !out_ready) check("stall_gates_en", 80'(cnn_clk_en), 80'(0));
    if (in_ready) check("input_passthru", 80'(cnn_input_data), 80'(in_data));
    else if (!busy) check("idle_input_zero", 80'(cnn_input_data), 80'(0));
    if (in_valid && in_ready) begin
      fed_q.push_back(cnn_input_data);
      acc++;
    end
    if (cnn_clk_en) en_total++;
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (frame_done) fd_total++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy",       80'(busy),           80'(0));
    check("rst_in_ready",   80'(in_ready),       80'(0));
    check("rst_clk_en",     80'(cnn_clk_en),     80'(0));
    check("rst_out_valid",  80'(out_valid),      80'(0));
    check("rst_frame_done", 80'(frame_done),     80'(0));
    check("rst_timeout",    80'(timeout),        80'(0));
    check("rst_in_count",   80'(in_count),       80'(0));
    check("rst_out_count",  80'(out_count),      80'(0));
    check("rst_out_data",   out_data,            80'(0));
    check("rst_cnn_input",  80'(cnn_input_data), 80'(0));
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: out_ready held low, 3: random valid
  task automatic run_frame(input int mode, input bit inject_start, input bit expect_timeout);
    logic [DW-1:0] pix[NPIX];
    logic [79:0]   held;
    int fed0, got0, fd0, en0, cyc_n, hold, flush_edge, to_edge;
    bit injected;
    for (int i = 0; i < NPIX; i++) pix[i] = DW'($urandom());
    tag   = {$urandom(), $urandom()};
    fed0  = fed_q.size();
    got0  = got_q.size();
    fd0   = fd_total;
    en0   = en_total;
    held  = '0;
    hold  = 0;
    cyc_n = 0;
    flush_edge = -1;
    to_edge    = -1;
    injected   = 1'b0;

    acc       = 0;
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = (mode != 2);
    sample();
    start = 1'b0;
    check("start_busy",      80'(busy),      80'(1));
    check("start_timeout",   80'(timeout),   80'(0));
    check("start_in_count",  80'(in_count),  80'(0));
    check("start_out_count", 80'(out_count), 80'(0));

    while (fd_total == fd0 && cyc_n < 200) begin
      in_data = pix[(acc < NPIX) ? acc : 0];
      case (mode)
        1:       in_valid = (cyc_n % 2 == 0) && (acc < NPIX);
        3:       in_valid = ($urandom_range(0, 1) == 1) && (acc < NPIX);
        default: in_valid = (acc < NPIX);
      endcase
      if (mode == 2 && out_valid && !out_ready) begin
        hold++;
        if (hold == 1) held = out_data;
        else check("held_data_stable", out_data, held);
        check("held_in_ready", 80'(in_ready), 80'(0));
        if (hold == 6) out_ready = 1'b1;
      end
      if (inject_start && !injected && acc == 5) begin
        start    = 1'b1;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      sample();
      if (acc == NPIX && flush_edge < 0) flush_edge = cyc_n;
      if (timeout && to_edge < 0) to_edge = cyc_n;
      cyc_n++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("frame_done_seen", 80'(fd_total - fd0), 80'(1));
    sample();
    check("frame_done_once", 80'(fd_total - fd0), 80'(1));
    check("busy_low_after",  80'(busy),      80'(0));
    check("final_in_count",  80'(in_count),  80'(NPIX));
    check("final_out_count", 80'(out_count), 80'(expect_timeout ? 0 : OUTP));
    check("final_timeout",   80'(timeout),   80'(expect_timeout));
    check("fed_len", 80'(fed_q.size() - fed0), 80'(NPIX));
    for (int i = 0; i < NPIX && fed0 + i < fed_q.size(); i++)
      check("fed_pixel", 80'(fed_q[fed0 + i]), 80'(pix[i]));
    if (expect_timeout) begin
      check("to_cnn_en_cycles", 80'(en_total - en0), 80'(NPIX + FL));
      check("to_after_flush",   80'(to_edge - flush_edge), 80'(FL));
      check("to_no_results",    80'(got_q.size() - got0), 80'(0));
    end else begin
      check("cnn_en_cycles", 80'(en_total - en0), 80'(10));
      check("result_len",    80'(got_q.size() - got0), 80'(OUTP));
      if (got_q.size() - got0 >= 2) begin
        check("result0", got_q[got0],     {tag, 16'd4});
        check("result1", got_q[got0 + 1], {tag, 16'd9});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // No activity before the first start, even with input offered.
    in_valid = 1'b1;
    repeat (3) begin
      sample();
      check("pre_start_busy",     80'(busy),     80'(0));
      check("pre_start_in_ready", 80'(in_ready), 80'(0));
      check("pre_start_in_count", 80'(in_count), 80'(0));
    end
    in_valid = 1'b0;

    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0);
    stub_en = 1'b0;
    run_frame(0, 1'b0, 1'b1);
    stub_en = 1'b1;
    run_frame(0, 1'b0, 1'b0);

    // Mid-frame reset after three pixels, then a fresh frame.
    acc   = 0;
    start = 1'b1;
    sample();
    start    = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      in_data = DW'($urandom());
      sample();
    end
    check("pre_reset_pixels", 80'(acc), 80'(3));
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    acc = 0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    sample();
    run_frame(0, 1'b0, 1'b0);

    repeat (3) run_frame(3, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
